// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared FSM state type and press counter width for button_press_pulse
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/button_press_pulse_if.sv
// rtl/button_press_pulse_if.sv - button level in, press/held out; press_count only with BTN_PRESS_CNT_EN
interface button_press_pulse_if;
  import btn_pkg::*;

  logic btn_sync;
  logic press;
  logic held;
`ifdef BTN_PRESS_CNT_EN
  logic [PRESS_CNT_W-1:0] press_count;
`endif

`ifdef BTN_PRESS_CNT_EN
  modport master (input btn_sync, output press, output held, output press_count);
  modport slave  (output btn_sync, input press, input held, input press_count);
`else
  modport master (input btn_sync, output press, output held);
  modport slave  (output btn_sync, input press, input held);
`endif

endinterface

// File: rtl/button_press_pulse_debounce_counter.sv
// rtl/button_press_pulse_debounce_counter.sv - clearable/loadable up-counter flagging the last sample before terminal count
module debounce_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic at_last
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // True when the sample about to be taken is the N-th consecutive one
  assign at_last = (count == LAST);

endmodule

// File: rtl/button_press_pulse.sv
// rtl/button_press_pulse.sv - debounced held level and single-cycle press pulse; BTN_PRESS_CNT_EN adds press_count
module button_press_pulse
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  button_press_pulse_if.master bus
);

  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  btn_state_t state;
  logic       pressed;
  logic       press_q;
  logic       held_q;
  logic       cnt_clear;
  logic       cnt_load;
  logic       cnt_inc;
  logic       at_last;
  logic       fire;

  assign pressed = bus.btn_sync ^ ACTIVE_LOW;

  // Edge on which a press is accepted; drives both the pulse and the optional counter
  assign fire = pressed && (((state == IDLE) && SINGLE) || ((state == PRESS_WAIT) && at_last));

  always_comb begin
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        cnt_load  = pressed;
        cnt_clear = !pressed;
      end
      PRESS_WAIT: begin
        cnt_clear = !pressed || at_last;
        cnt_inc   = pressed && !at_last;
      end
      HELD: begin
        cnt_load  = !pressed;
        cnt_clear = pressed;
      end
      RELEASE_WAIT: begin
        cnt_clear = pressed || at_last;
        cnt_inc   = !pressed && !at_last;
      end
      default: cnt_clear = 1'b1;
    endcase
  end

  debounce_counter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .at_last(at_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      press_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      press_q <= fire;
      if (fire) held_q <= 1'b1;
      case (state)
        IDLE: begin
          if (pressed) state <= SINGLE ? HELD : PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!pressed) state <= IDLE;
          else if (at_last) state <= HELD;
        end
        HELD: begin
          if (!pressed) begin
            if (SINGLE) begin
              state  <= IDLE;
              held_q <= 1'b0;
            end else begin
              state <= RELEASE_WAIT;
            end
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed keeps held without a new pulse
          if (pressed) begin
            state <= HELD;
          end else if (at_last) begin
            state  <= IDLE;
            held_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.press = press_q;
  assign bus.held  = held_q;

`ifdef BTN_PRESS_CNT_EN
  logic [PRESS_CNT_W-1:0] press_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      press_count_q <= '0;
    end else if (fire && (press_count_q != {PRESS_CNT_W{1'b1}})) begin
      press_count_q <= press_count_q + PRESS_CNT_W'(1);
    end
  end

  assign bus.press_count = press_count_q;
`endif

endmodule

// File: doc/button_press_pulse.md
# button_press_pulse

Debounces a synchronized player-button level and emits exactly one single-cycle `press` pulse per physical press, plus a clean debounced `held` level. Sits directly downstream of the two-flop input synchronizer on each player key, and directly upstream of the tug-of-war position/scoring logic, which consumes `press` as a one-cycle "pull" request.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4. Number of consecutive identical samples required to accept a level change. Legal range is 1..65535. Simulation uses 4; the board build overrides it.
- `ACTIVE_LOW`, 1. When 1, `btn_sync` = 0 means pressed (board KEYs). When 0, `btn_sync` = 1 means pressed.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `btn_sync`  in  1  already-synchronized button level. The block adds no synchronizer of its own.
- `press`  out  1  registered one-cycle pulse per accepted press.
- `held`  out  1  registered debounced level; 1 while the button is accepted as pressed.
- `press_count`  out  8  saturating count of press pulses. Present only when `BTN_PRESS_CNT_EN` is defined.

## Operation
- Internal `pressed` = `btn_sync` XOR `ACTIVE_LOW`.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- IDLE: if `pressed` is sampled, count = 1.
  - If `DEBOUNCE_CYCLES` = 1, go directly to HELD and fire `press`.
  - Otherwise go to PRESS_WAIT.
- PRESS_WAIT: if `pressed` is sampled, count increments.
  - When the count reaches `DEBOUNCE_CYCLES`, go to HELD, set `held` = 1, and pulse `press`.
  - If not-pressed is sampled, go to IDLE and clear the count.
- HELD: if not-pressed is sampled, count = 1.
  - If `DEBOUNCE_CYCLES` = 1, go directly to IDLE and set `held` = 0.
  - Otherwise go to RELEASE_WAIT.
- RELEASE_WAIT: if not-pressed is sampled, count increments.
  - When the count reaches `DEBOUNCE_CYCLES`, go to IDLE and set `held` = 0.
  - If `pressed` is sampled, return to HELD and clear the count. No new `press` is generated.
- `press` is high only in the cycle immediately after the transition into HELD from IDLE or PRESS_WAIT. It is never high two consecutive cycles.
- Reset while in any state: on the next posedge the state is IDLE, the count is 0, and `press`, `held` and `press_count` are 0.
  - A button still held when reset deasserts is treated as a new press. It needs a full `DEBOUNCE_CYCLES` samples and then pulses.

## Timing
- Reset values: `press` = 0, `held` = 0, `press_count` = 0, state = IDLE.
- Press latency: take the N-th consecutive pressed sample (N = `DEBOUNCE_CYCLES`) at edge k. `press` and `held` are both 1 after edge k. `press` returns to 0 after edge k+1.
- Release latency: `held` falls after the edge of the N-th consecutive not-pressed sample.
- Minimum press-to-press spacing: 2N cycles.
- No combinational path from `btn_sync` to any output.

## Configuration
- `BTN_PRESS_CNT_EN` defined: adds the `press_count` port.
  - 8-bit counter; increments in the same edge that sets `press`.
  - Saturates at 255.
  - Cleared only by `reset`.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `btn_pkg`:
  - typedef enum `btn_state_t` {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - constant `PRESS_CNT_W` = 8.
- One sub-module, `debounce_counter`: loadable/clearable up-counter with terminal-count compare. It is parameterized by `DEBOUNCE_CYCLES`. The FSM stays in `button_press_pulse`.

## Test plan
Conditions for all scenarios: `DEBOUNCE_CYCLES` = 4, `ACTIVE_LOW` = 0.
- Reset: hold `reset` = 1 for 2 cycles with `btn_sync` = 1 → `press` = `held` = 0 throughout. After release, `press` fires on the 4th pressed sample.
- Clean press: `btn_sync` = 1 for 10 cycles, then 0 for 6 → `press` is high exactly 1 cycle, after the 4th sample edge. `held` is high from that edge until the 4th 0-sample edge.
- Press bounce: 1,1,1,0,1,1,1,1 → exactly one `press`, after the 8th sample.
- Release bounce: in HELD, 0,0,1,0,0,0,0 → `held` stays 1 through the glitch, falls after the last 0, and there is no second `press`.
- Reset mid-HELD: assert `reset` for 1 cycle while `btn_sync` = 1 → `held` = 0 the next cycle. Then exactly one `press` 4 samples after deassertion.
- With `BTN_PRESS_CNT_EN` defined: 300 clean presses → `press_count` reads 1, 2, … and holds at 255 after the 255th press.
